// File: rtl/alu_issue_ctrl.sv
// Single-issue operand-fetch / writeback controller for the 16-bit alu (IDLE -> EXEC -> WB).
// Optional macro ALU_DIV0_TRAP_EN: trap divide-by-zero (no writeback) instead of writing 16'hFFFF.
module alu_issue_ctrl #(
  parameter int NREGS = 8,
  parameter int RAW   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [3:0]     cmd_opcode,
  input  logic [RAW-1:0] cmd_rd,
  input  logic [RAW-1:0] cmd_rs1,
  input  logic [RAW-1:0] cmd_rs2,
  input  logic           cmd_use_imm,
  input  logic [15:0]    cmd_imm,
  output logic [15:0]    alu_a,
  output logic [15:0]    alu_b,
  output logic [3:0]     alu_opcode,
  input  logic [15:0]    alu_op,
  input  logic [4:0]     alu_flags,
  output logic           res_valid,
  output logic [15:0]    res_data,
  output logic [RAW-1:0] res_rd,
  output logic [4:0]     flags,
  output logic           err_div0,
  input  logic [RAW-1:0] dbg_raddr,
  output logic [15:0]    dbg_rdata
);

  localparam int         DATA_W = 16;
  localparam logic [3:0] OP_DIV = 4'b0011;
`ifdef ALU_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [NREGS];
  logic [RAW-1:0]    rd_p1;
  logic [4:0]        flags_hold_p2;
  logic              div0_p1, div0_p2;
  logic              accept;

  assign accept    = cmd_valid && cmd_ready;
  assign div0_p1   = (alu_opcode == OP_DIV) && (alu_b == '0);
  assign dbg_rdata = regs[dbg_raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rd_p1         <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_opcode    <= '0;
      res_data      <= '0;
      res_rd        <= '0;
      res_valid     <= 1'b0;
      flags_hold_p2 <= '0;
      div0_p2       <= 1'b0;
      flags         <= '0;
    end else begin
      case (state)
        // p0 -> p1: operand fetch at accept
        IDLE: begin
          if (accept) begin
            rd_p1      <= cmd_rd;
            alu_a      <= regs[cmd_rs1];
            alu_b      <= cmd_use_imm ? cmd_imm : regs[cmd_rs2];
            alu_opcode <= cmd_opcode;
          end
        end
        // p1 -> p2: capture alu result and flags
        EXEC: begin
          res_data      <= (div0_p1 && !TRAP_EN) ? {DATA_W{1'b1}} : alu_op;
          res_rd        <= rd_p1;
          flags_hold_p2 <= alu_flags;
          div0_p2       <= div0_p1;
          res_valid     <= !(TRAP_EN && div0_p1);
        end
        // p2 -> architectural state: register and flag writeback
        WB: begin
          res_valid <= 1'b0;
          if (!(TRAP_EN && div0_p2)) regs[res_rd] <= res_data;
          if (!div0_p2) flags <= flags_hold_p2;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_DIV0_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_div0 <= 1'b0;
    else        err_div0 <= (state == EXEC) && div0_p1;
  end
`else
  assign err_div0 = 1'b0;
`endif

endmodule
